// File: rtl/sa_ram_fifo_ctrl_256x8.sv
// Valid/ready FIFO controller using an external 256x8 two-port RAM as storage.
// A 2-entry output buffer prefetches RAM reads to hide the registered-address latency.
module sa_ram_fifo_ctrl_256x8 #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          in_pvld,
   output logic          in_prdy,
   input  logic [DW-1:0] in_pd,
   output logic          out_pvld,
   input  logic          out_prdy,
   output logic [DW-1:0] out_pd,
   input  logic          flush,
   output logic [AW+1:0] fifo_cnt,
   output logic          ram_we,
   output logic [AW-1:0] ram_wa,
   output logic [DW-1:0] ram_di,
   output logic          ram_re,
   output logic [AW-1:0] ram_ra,
   input  logic [DW-1:0] ram_dout,
   input  logic [31:0]   pwrbus_ram_pd,
   output logic [31:0]   ram_pwrbus_ram_pd
);

   localparam int unsigned DEPTH = 2 ** AW;

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   ram_cnt;
   logic          rd_inflight;
   logic [1:0]    out_cnt;
   logic          out_hd;
   logic [DW-1:0] obuf [2];

   logic          push;
   logic          pop;
   logic [2:0]    pend;
   logic [AW:0]   ram_cnt_d;
   logic [1:0]    out_cnt_d;
   logic [AW+1:0] fifo_cnt_d;

   assign in_prdy  = rstn & ~flush & (ram_cnt != (AW+1)'(DEPTH));
   assign out_pvld = rstn & (out_cnt != 2'd0);
   assign push     = in_pvld & in_prdy;
   assign pop      = out_pvld & out_prdy;

   // Keep at most two beats between the in-flight read and the output buffer.
   assign pend   = {1'b0, out_cnt} + {2'b00, rd_inflight};
   assign ram_re = rstn & ~flush & (ram_cnt != '0) & (pend < (3'd2 + {2'b00, pop}));

   assign ram_we            = push;
   assign ram_wa            = wr_ptr;
   assign ram_di            = in_pd;
   assign ram_ra            = rd_ptr;
   assign out_pd            = obuf[out_hd];
   assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

   always_comb begin
      ram_cnt_d  = ram_cnt + (AW+1)'(push) - (AW+1)'(ram_re);
      out_cnt_d  = out_cnt + 2'(rd_inflight) - 2'(pop);
      fifo_cnt_d = (AW+2)'(ram_cnt_d) + (AW+2)'(ram_re) + (AW+2)'(out_cnt_d);
   end

   always_ff @(posedge clk) begin
      if (!rstn || flush) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         ram_cnt     <= '0;
         rd_inflight <= 1'b0;
         out_cnt     <= 2'd0;
         out_hd      <= 1'b0;
         fifo_cnt    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (ram_re) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         // Captured beat lands behind the current occupants of the buffer.
         if (rd_inflight) begin
            obuf[out_hd ^ out_cnt[0]] <= ram_dout;
         end
         if (pop) begin
            out_hd <= ~out_hd;
         end
         ram_cnt     <= ram_cnt_d;
         rd_inflight <= ram_re;
         out_cnt     <= out_cnt_d;
         fifo_cnt    <= fifo_cnt_d;
      end
   end

endmodule

// File: tb/tb_sa_ram_fifo_ctrl_256x8.sv
// Self-checking bench: behavioural RAM, queue-based reference model, randomized traffic.
module tb_sa_ram_fifo_ctrl_256x8;

   logic        clk = 1'b0;
   logic        rstn;
   logic        in_pvld;
   logic        in_prdy;
   logic [7:0]  in_pd;
   logic        out_pvld;
   logic        out_prdy;
   logic [7:0]  out_pd;
   logic        flush;
   logic [9:0]  fifo_cnt;
   logic        ram_we;
   logic [7:0]  ram_wa;
   logic [7:0]  ram_di;
   logic        ram_re;
   logic [7:0]  ram_ra;
   logic [7:0]  ram_dout;
   logic [31:0] pwrbus_ram_pd;
   logic [31:0] ram_pwrbus_ram_pd;

   int checks = 0;
   int errors = 0;
   logic [7:0] q[$];

   logic [7:0]   mem [256];
   logic [7:0]   ra_q;
   logic [255:0] written;

   always #5 clk = ~clk;

   sa_ram_fifo_ctrl_256x8 #(.AW(8), .DW(8)) dut (
      .clk              (clk),
      .rstn             (rstn),
      .in_pvld          (in_pvld),
      .in_prdy          (in_prdy),
      .in_pd            (in_pd),
      .out_pvld         (out_pvld),
      .out_prdy         (out_prdy),
      .out_pd           (out_pd),
      .flush            (flush),
      .fifo_cnt         (fifo_cnt),
      .ram_we           (ram_we),
      .ram_wa           (ram_wa),
      .ram_di           (ram_di),
      .ram_re           (ram_re),
      .ram_ra           (ram_ra),
      .ram_dout         (ram_dout),
      .pwrbus_ram_pd    (pwrbus_ram_pd),
      .ram_pwrbus_ram_pd(ram_pwrbus_ram_pd)
   );

   // External RAM: registered read address, combinational data out.
   always @(posedge clk) begin
      if (ram_we) mem[ram_wa] <= ram_di;
      if (ram_re) ra_q <= ram_ra;
      if (!rstn || flush) begin
         written <= '0;
      end else begin
         if (ram_re) written[ram_ra] <= 1'b0;
         if (ram_we) written[ram_wa] <= 1'b1;
      end
   end
   assign ram_dout = mem[ra_q];

   task automatic test_reset();
      rstn = 1'b0; in_pvld = 1'b1; in_pd = 8'h33; out_prdy = 1'b1; flush = 1'b0;
      pwrbus_ram_pd = 32'hDEADBEEF;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (in_prdy !== 1'b0) begin errors++; $display("FAIL reset_in_prdy got %b want 0", in_prdy); end
      checks++; if (out_pvld !== 1'b0) begin errors++; $display("FAIL reset_out_pvld got %b want 0", out_pvld); end
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got %b want 0", ram_we); end
      checks++; if (ram_re !== 1'b0) begin errors++; $display("FAIL reset_ram_re got %b want 0", ram_re); end
      checks++; if (fifo_cnt !== 10'd0) begin errors++; $display("FAIL reset_fifo_cnt got %0d want 0", fifo_cnt); end
      checks++;
      if (ram_pwrbus_ram_pd !== 32'hDEADBEEF) begin
         errors++; $display("FAIL pwrbus got %h want deadbeef", ram_pwrbus_ram_pd);
      end
      @(negedge clk);
      rstn = 1'b1; in_pvld = 1'b0;
   endtask

   task automatic test_single();
      @(negedge clk);
      in_pvld = 1'b1; in_pd = 8'h11; out_prdy = 1'b1; #1;
      checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL single_we got %b want 1", ram_we); end
      checks++; if (ram_wa !== 8'h00) begin errors++; $display("FAIL single_wa got %h want 00", ram_wa); end
      checks++; if (ram_di !== 8'h11) begin errors++; $display("FAIL single_di got %h want 11", ram_di); end
      @(negedge clk);
      in_pvld = 1'b0; #1;
      checks++; if (ram_re !== 1'b1) begin errors++; $display("FAIL single_re got %b want 1", ram_re); end
      checks++; if (ram_ra !== 8'h00) begin errors++; $display("FAIL single_ra got %h want 00", ram_ra); end
      checks++; if (out_pvld !== 1'b0) begin errors++; $display("FAIL single_pvld_c1 got %b want 0", out_pvld); end
      @(negedge clk); #1;
      checks++; if (out_pvld !== 1'b0) begin errors++; $display("FAIL single_pvld_c2 got %b want 0", out_pvld); end
      @(negedge clk); #1;
      checks++; if (out_pvld !== 1'b1) begin errors++; $display("FAIL single_pvld_c3 got %b want 1", out_pvld); end
      checks++; if (out_pd !== 8'h11) begin errors++; $display("FAIL single_pd got %h want 11", out_pd); end
      checks++; if (fifo_cnt !== 10'd1) begin errors++; $display("FAIL single_cnt_c3 got %0d want 1", fifo_cnt); end
      @(negedge clk); #1;
      checks++; if (out_pvld !== 1'b0) begin errors++; $display("FAIL single_pvld_c4 got %b want 0", out_pvld); end
      checks++; if (fifo_cnt !== 10'd0) begin errors++; $display("FAIL single_cnt_c4 got %0d want 0", fifo_cnt); end
   endtask

   task automatic test_fill();
      int drops = 0;
      for (int i = 0; i < 258; i++) begin
         @(negedge clk);
         in_pvld = 1'b1; out_prdy = 1'b0;
         in_pd = (i < 256) ? 8'(i) : 8'(8'hA0 + i - 256);
         #1;
         if (in_prdy !== 1'b1) drops++;
         else q.push_back(in_pd);
      end
      checks++; if (drops != 0) begin errors++; $display("FAIL fill_prdy_drops got %0d want 0", drops); end
      @(negedge clk);
      in_pvld = 1'b1; in_pd = 8'hFF; #1;
      checks++; if (in_prdy !== 1'b0) begin errors++; $display("FAIL fill_full_prdy got %b want 0", in_prdy); end
      checks++; if (fifo_cnt !== 10'd258) begin errors++; $display("FAIL fill_cnt got %0d want 258", fifo_cnt); end
      checks++; if (out_pvld !== 1'b1) begin errors++; $display("FAIL fill_pvld got %b want 1", out_pvld); end
      for (int c = 0; c < 400 && q.size() > 0; c++) begin
         @(negedge clk);
         in_pvld = 1'b0; out_prdy = 1'b1; #1;
         if (out_pvld === 1'b1) begin
            checks++;
            if (out_pd !== q[0]) begin errors++; $display("FAIL fill_drain_data got %h want %h", out_pd, q[0]); end
            void'(q.pop_front());
         end
      end
      checks++; if (q.size() != 0) begin errors++; $display("FAIL fill_drain_left got %0d want 0", q.size()); end
      q.delete();
      @(negedge clk); #1;
      checks++; if (fifo_cnt !== 10'd0) begin errors++; $display("FAIL fill_end_cnt got %0d want 0", fifo_cnt); end
   endtask

   task automatic test_stream();
      int sent = 0, rcvd = 0, first = -1, bubbles = 0;
      for (int c = 0; c < 700 && rcvd < 600; c++) begin
         @(negedge clk);
         in_pvld = (sent < 600); in_pd = 8'(sent); out_prdy = 1'b1; #1;
         if (in_pvld && in_prdy) sent++;
         if (out_pvld === 1'b1) begin
            if (first < 0) first = c;
            checks++;
            if (out_pd !== 8'(rcvd)) begin errors++; $display("FAIL stream_data got %h want %h", out_pd, 8'(rcvd)); end
            rcvd++;
         end else if (first >= 0) begin
            bubbles++;
         end
      end
      in_pvld = 1'b0;
      checks++; if (first != 3) begin errors++; $display("FAIL stream_latency got %0d want 3", first); end
      checks++; if (bubbles != 0) begin errors++; $display("FAIL stream_bubbles got %0d want 0", bubbles); end
      checks++; if (rcvd != 600) begin errors++; $display("FAIL stream_count got %0d want 600", rcvd); end
      @(negedge clk); #1;
      checks++; if (fifo_cnt !== 10'd0) begin errors++; $display("FAIL stream_end_cnt got %0d want 0", fifo_cnt); end
   endtask

   task automatic test_random();
      int sent = 0, rcvd = 0, mcnt = 0;
      q.delete();
      for (int c = 0; c < 20000 && rcvd < 2000; c++) begin
         @(negedge clk);
         checks++;
         if (fifo_cnt !== 10'(mcnt)) begin errors++; $display("FAIL rand_cnt got %0d want %0d", fifo_cnt, mcnt); end
         in_pvld = (sent < 2000) && ($urandom_range(0, 1) == 1);
         in_pd = 8'($urandom);
         out_prdy = ($urandom_range(0, 1) == 1);
         #1;
         if (out_pvld === 1'b1 && out_prdy) begin
            checks++;
            if (q.size() == 0 || out_pd !== q[0]) begin
               errors++; $display("FAIL rand_data got %h want %h (model size %0d)", out_pd,
                                  (q.size() > 0) ? q[0] : 8'h00, q.size());
            end
            if (q.size() > 0) void'(q.pop_front());
            rcvd++; mcnt--;
         end
         if (ram_re === 1'b1) begin
            checks++;
            if (written[ram_ra] !== 1'b1) begin errors++; $display("FAIL rand_unwritten_ra got addr %h want written", ram_ra); end
         end
         if (in_pvld && in_prdy === 1'b1) begin
            q.push_back(in_pd); sent++; mcnt++;
         end
      end
      in_pvld = 1'b0;
      checks++; if (rcvd != 2000) begin errors++; $display("FAIL rand_count got %0d want 2000", rcvd); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_pvld = 1'b1; in_pd = 8'($urandom); out_prdy = 1'b0;
      end
      @(negedge clk);
      in_pvld = 1'b0;
      @(negedge clk);
      out_prdy = 1'b1; #1;
      checks++; if (ram_re !== 1'b1) begin errors++; $display("FAIL flush_pre_re got %b want 1", ram_re); end
      @(negedge clk);
      out_prdy = 1'b0; flush = 1'b1; in_pvld = 1'b1; in_pd = 8'hEE; #1;
      checks++; if (ram_re !== 1'b0) begin errors++; $display("FAIL flush_re got %b want 0", ram_re); end
      checks++; if (in_prdy !== 1'b0) begin errors++; $display("FAIL flush_prdy got %b want 0", in_prdy); end
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL flush_we got %b want 0", ram_we); end
      checks++; if (out_pvld !== 1'b1) begin errors++; $display("FAIL flush_pvld got %b want 1", out_pvld); end
      checks++; if (fifo_cnt !== 10'd9) begin errors++; $display("FAIL flush_pre_cnt got %0d want 9", fifo_cnt); end
      @(negedge clk);
      flush = 1'b0; in_pvld = 1'b1; in_pd = 8'h5A; out_prdy = 1'b1; #1;
      checks++; if (fifo_cnt !== 10'd0) begin errors++; $display("FAIL flush_cnt got %0d want 0", fifo_cnt); end
      checks++; if (out_pvld !== 1'b0) begin errors++; $display("FAIL flush_post_pvld got %b want 0", out_pvld); end
      checks++; if (in_prdy !== 1'b1) begin errors++; $display("FAIL flush_post_prdy got %b want 1", in_prdy); end
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         in_pvld = 1'b0; #1;
         checks++;
         if (out_pvld !== (c == 3)) begin errors++; $display("FAIL flush_lat_c%0d got %b want %b", c, out_pvld, (c == 3)); end
         if (c == 3) begin
            checks++; if (out_pd !== 8'h5A) begin errors++; $display("FAIL flush_first got %h want 5a", out_pd); end
         end
      end
   endtask

   task automatic test_reset_mid();
      int nb = 0, firstc = -1;
      logic [7:0] val = 8'h00;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_pvld = 1'b1; in_pd = 8'(8'h40 + i); out_prdy = 1'b0;
      end
      repeat (3) begin
         @(negedge clk);
         in_pvld = 1'b0;
      end
      #1;
      checks++; if (fifo_cnt !== 10'd5) begin errors++; $display("FAIL rmid_pre_cnt got %0d want 5", fifo_cnt); end
      @(negedge clk);
      rstn = 1'b0; in_pvld = 1'b1; in_pd = 8'h77; out_prdy = 1'b1; #1;
      checks++; if (in_prdy !== 1'b0) begin errors++; $display("FAIL rmid_prdy got %b want 0", in_prdy); end
      checks++; if (out_pvld !== 1'b0) begin errors++; $display("FAIL rmid_pvld got %b want 0", out_pvld); end
      checks++; if (ram_re !== 1'b0) begin errors++; $display("FAIL rmid_re got %b want 0", ram_re); end
      @(negedge clk);
      rstn = 1'b1; in_pvld = 1'b1; in_pd = 8'hC3; out_prdy = 1'b1; #1;
      checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL rmid_we got %b want 1", ram_we); end
      checks++; if (ram_wa !== 8'h00) begin errors++; $display("FAIL rmid_wa got %h want 00", ram_wa); end
      checks++; if (fifo_cnt !== 10'd0) begin errors++; $display("FAIL rmid_cnt got %0d want 0", fifo_cnt); end
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         in_pvld = 1'b0; #1;
         if (out_pvld === 1'b1) begin
            if (firstc < 0) begin firstc = c; val = out_pd; end
            nb++;
         end
      end
      checks++; if (nb != 1) begin errors++; $display("FAIL rmid_beats got %0d want 1", nb); end
      checks++; if (firstc != 3) begin errors++; $display("FAIL rmid_latency got %0d want 3", firstc); end
      checks++; if (val !== 8'hC3) begin errors++; $display("FAIL rmid_data got %h want c3", val); end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_stream();
      test_random();
      test_flush();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
